// File: rtl/pow2_sched_pkg.sv
// Shared widths and the stage-A bundle for the exponent scheduler.
// The ID field is sized for the largest supported requester count.
package pow2_sched_pkg;

    localparam int DATA_W   = 8;
    localparam int EXP_W    = 3;
    localparam int ID_MAX_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [ID_MAX_W-1:0] id;
        logic                valid;
    } stage_a_t;

endpackage

// File: rtl/find_pow2_8.sv
// exp = ceil(log2 x) - 1 for 8-bit x, 0 for x <= 2.
// Computed as the MSB position of x-1.
module find_pow2_8
    import pow2_sched_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    output logic [EXP_W-1:0]  exp
);

    logic [DATA_W-1:0] xm1;

    always_comb begin
        xm1 = x - DATA_W'(1);
        exp = '0;
        if (x > DATA_W'(2)) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (xm1[i]) exp = EXP_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arb_onehot.sv
// Round-robin arbiter: first set request at or after ptr, wrapping.
// Produces a one-hot grant and its encoded index.
module rr_arb_onehot #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;
    int   k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/pow2_exp_scheduler.sv
// Round-robin scheduler sharing one find_pow2_8 unit between requesters.
// Two register stages: operand capture (A) and result output (B).
module pow2_exp_scheduler
    import pow2_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [DATA_W*N_REQ-1:0] data_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W-1:0]        out_exp,
    output logic                    out_zero,
    output logic [ID_W-1:0]         out_id
);

    stage_a_t          a_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   arb_idx;
    logic [N_REQ-1:0]  arb_gnt;
    logic [DATA_W-1:0] sel_data;
    logic [EXP_W-1:0]  exp_a;
    logic              can_a;
    logic              can_b;
    logic              accept;
    logic              unused_id_bits;

    rr_arb_onehot #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    find_pow2_8 u_exp (
        .x   (a_q.data),
        .exp (exp_a)
    );

    assign can_b    = !out_valid || out_ready;
    assign can_a    = !a_q.valid || can_b;
    // Gated by rst_n so grants vanish the moment reset asserts.
    assign gnt_o    = (can_a && rst_n) ? arb_gnt : '0;
    assign accept   = |(req_i & gnt_o);
    assign sel_data = data_i[arb_idx*DATA_W +: DATA_W];
    assign unused_id_bits = ^a_q.id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            ptr_q <= '0;
        end else if (accept) begin
            a_q.data  <= sel_data;
            a_q.id    <= ID_MAX_W'(arb_idx);
            a_q.valid <= 1'b1;
            ptr_q     <= (arb_idx == ID_W'(N_REQ - 1)) ?
                         '0 : arb_idx + ID_W'(1);
        end else if (can_b) begin
            a_q.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_id    <= '0;
        end else if (can_b && a_q.valid) begin
            out_valid <= 1'b1;
            out_exp   <= exp_a;
            out_zero  <= (a_q.data == '0);
            out_id    <= a_q.id[ID_W-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pow2_exp_scheduler.sv
// Bench for pow2_exp_scheduler: queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pow2_exp_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_i;
    logic [8*N-1:0] data_i;
    logic [N-1:0]   gnt_o;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     out_exp;
    logic           out_zero;
    logic [1:0]     out_id;

    always #5 clk = ~clk;

    pow2_exp_scheduler #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .data_i    (data_i),
        .gnt_o     (gnt_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_id    (out_id)
    );

    typedef struct {
        int data;
        int id;
        int age;
    } item_t;

    item_t      q[$];
    int         ptr;
    int         checks   = 0;
    int         failures = 0;
    int         acc_lane;
    int         n_acc;
    int         n_pop;
    logic [N-1:0] s_gnt;
    logic       s_valid;
    logic [2:0] s_exp;
    logic       s_zero;
    logic [1:0] s_id;

    int bvals[8] = '{0, 1, 2, 3, 4, 128, 129, 255};
    int bexps[8] = '{0, 0, 0, 1, 1, 6, 7, 7};

    function automatic int ref_exp(int x);
        int c = 0;
        while ((1 << c) < x) c++;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic int pick(logic [N-1:0] r, int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] v = '0;
        int g;
        if (!rst_n) return v;
        g = pick(req_i, ptr);
        if (g >= 0 && (q.size() < 2 || out_ready)) v[g] = 1'b1;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        int g;
        bit vis;
        bit allowed;
        @(negedge clk);
        s_gnt   = gnt_o;
        s_valid = out_valid;
        s_exp   = out_exp;
        s_zero  = out_zero;
        s_id    = out_id;
        check("gnt", gnt_o, exp_gnt());
        vis = rst_n && q.size() > 0 && q[0].age >= 2;
        check("out_valid", out_valid, vis);
        if (vis) begin
            check("out_exp", out_exp, ref_exp(q[0].data));
            check("out_zero", out_zero, q[0].data == 0);
            check("out_id", out_id, q[0].id);
        end
        @(posedge clk);
        acc_lane = -1;
        if (rst_n) begin
            allowed = q.size() < 2 || out_ready;
            g = pick(req_i, ptr);
            if (vis && out_ready) begin
                void'(q.pop_front());
                n_pop++;
            end
            foreach (q[i]) q[i].age++;
            if (allowed && g >= 0) begin
                q.push_back('{int'(data_i[8*g +: 8]), g, 1});
                ptr = (g + 1) % N;
                acc_lane = g;
                n_acc++;
            end
        end
        #1;
    endtask

    function automatic logic [7:0] rand_val();
        if ($urandom % 4 == 0) return 8'(bvals[$urandom % 8]);
        return 8'($urandom % 256);
    endfunction

    task automatic drain(int n);
        req_i = '0;
        out_ready = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic rand_phase(int n);
        repeat (n) begin
            for (int k = 0; k < N; k++) begin
                if (!req_i[k]) begin
                    if ($urandom % 3 == 0) begin
                        req_i[k] = 1'b1;
                        data_i[8*k +: 8] = rand_val();
                    end
                end else if ($urandom % 50 == 0) begin
                    req_i[k] = 1'b0;
                end
            end
            out_ready = ($urandom % 4) != 0;
            cycle();
            if (acc_lane >= 0) req_i[acc_lane] = 1'b0;
        end
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        logic [1:0] held_id;
        ptr = 0;
        n_acc = 0;
        n_pop = 0;
        rst_n = 1'b0;
        req_i = '0;
        data_i = '0;
        out_ready = 1'b0;

        for (int j = 0; j < 8; j++)
            check("model_exp", ref_exp(bvals[j]), bexps[j]);

        #12;
        req_i = '1;
        #1;
        check("rst_gnt", gnt_o, 0);
        check("rst_valid", out_valid, 0);
        check("rst_exp", out_exp, 0);
        check("rst_zero", out_zero, 0);
        check("rst_id", out_id, 0);
        req_i = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all four requesting continuously
        req_i = '1;
        data_i = {8'd200, 8'd0, 8'd17, 8'd3};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_order", acc_lane, order[i]);
            if (i >= 2) begin
                check("rr_valid", s_valid, 1);
                check("rr_id", s_id, order[i-2]);
            end
        end
        drain(4);

        // stall with all requesting
        req_i = '1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i == 2) held_id = s_id;
        end
        check("stall_gnt", s_gnt, 0);
        check("stall_valid", s_valid, 1);
        check("stall_id_hold", s_id, held_id);
        out_ready = 1'b1;
        repeat (6) cycle();
        drain(4);
        check("no_loss", n_pop, n_acc);

        // single request, lane 0, x=5
        req_i = 4'b0001;
        data_i[7:0] = 8'd5;
        cycle();
        check("single_gnt", s_gnt, 4'b0001);
        req_i = '0;
        cycle();
        cycle();
        check("single_valid", s_valid, 1);
        check("single_exp", s_exp, 2);
        check("single_id", s_id, 0);
        drain(2);

        // boundary operands through lane 2
        for (int j = 0; j < 8; j++) begin
            req_i = 4'b0100;
            data_i[23:16] = 8'(bvals[j]);
            cycle();
            check("bnd_lane", acc_lane, 2);
            req_i = '0;
            cycle();
            cycle();
            check("bnd_valid", s_valid, 1);
            check("bnd_exp", s_exp, bexps[j]);
            check("bnd_zero", s_zero, j == 0);
        end

        // wrap from ptr=3
        req_i = 4'b1001;
        data_i[7:0] = 8'd9;
        data_i[31:24] = 8'd50;
        cycle();
        check("wrap_first", s_gnt, 4'b1000);
        req_i = 4'b0001;
        cycle();
        check("wrap_second", s_gnt, 4'b0001);
        drain(4);

        rand_phase(1500);

        // async reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_gnt", gnt_o, 0);
        q.delete();
        ptr = 0;
        cycle();
        rst_n = 1'b1;
        req_i = 4'b0110;
        cycle();
        check("arst_first", s_gnt, 4'b0010);
        req_i[1] = 1'b0;

        rand_phase(500);
        drain(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
